// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one UART transmitter between NUM_REQ byte producers.
// Latches the winner's byte/parity, issues a one-cycle start pulse, then tracks tx_busy.
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned BUSY_TIMEOUT = 15
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic                          arb_en,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            cfg_par_en,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          tx_busy,
    output logic                          tx_data_valid,
    output logic [DATA_WIDTH-1:0]         tx_p_data,
    output logic                          tx_par_en,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic                          arb_active,
    output logic                          timeout_err
);

    localparam int unsigned IDW  = $clog2(NUM_REQ);
    localparam int unsigned CNTW = $clog2(BUSY_TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_ARB       = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_WAIT_DONE = 2'd3
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [IDW-1:0]        rr_ptr_q;
    logic [IDW-1:0]        rr_ptr_d;
    logic [CNTW-1:0]       cnt_q;
    logic [CNTW-1:0]       cnt_d;

    logic [DATA_WIDTH-1:0] req_bytes [NUM_REQ];
    logic [IDW-1:0]        cand;
    logic [IDW-1:0]        win_idx;
    logic                  win_found;
    logic                  grant;
    logic                  timeout_hit;

    logic [NUM_REQ-1:0]    req_ready_d;
    logic                  tx_data_valid_d;
    logic [DATA_WIDTH-1:0] tx_p_data_d;
    logic                  tx_par_en_d;
    logic [IDW-1:0]        grant_id_d;
    logic                  arb_active_d;
    logic                  timeout_err_d;

    // Unpack the flat data bus into one byte per requester
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_bytes
        assign req_bytes[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end

    // First pending requester at or after rr_ptr, wrapping modulo NUM_REQ
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = IDW'((32'(rr_ptr_q) + i) % NUM_REQ);
            if (!win_found && req_valid[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    assign grant       = (state_q == ST_ARB) && arb_en && !tx_busy && win_found;
    assign timeout_hit = (state_q == ST_WAIT_BUSY) && !tx_busy
                         && (cnt_q == CNTW'(BUSY_TIMEOUT - 1));

    // State register
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= ST_ARB;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_ARB: begin
                if (grant) begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (tx_busy) begin
                    state_d = ST_WAIT_DONE;
                end else if (timeout_hit) begin
                    state_d = ST_ARB;
                end
            end
            ST_WAIT_DONE: begin
                if (!tx_busy) begin
                    state_d = ST_ARB;
                end
            end
            default: begin
                state_d = ST_ARB;
            end
        endcase
    end

    // Next values of the registered outputs, pointer and busy-wait counter
    always_comb begin
        req_ready_d     = '0;
        tx_data_valid_d = 1'b0;
        timeout_err_d   = 1'b0;
        tx_p_data_d     = tx_p_data;
        tx_par_en_d     = tx_par_en;
        grant_id_d      = grant_id;
        arb_active_d    = arb_active;
        rr_ptr_d        = rr_ptr_q;
        cnt_d           = cnt_q;
        unique case (state_q)
            ST_ARB: begin
                if (grant) begin
                    tx_p_data_d = req_bytes[win_idx];
                    tx_par_en_d = cfg_par_en[win_idx];
                    grant_id_d  = win_idx;
                    rr_ptr_d    = (win_idx == IDW'(NUM_REQ - 1)) ? '0 : win_idx + IDW'(1);
                end
            end
            ST_ISSUE: begin
                tx_data_valid_d       = 1'b1;
                req_ready_d[grant_id] = 1'b1;
                arb_active_d          = 1'b1;
                cnt_d                 = '0;
            end
            ST_WAIT_BUSY: begin
                if (!tx_busy) begin
                    cnt_d = cnt_q + CNTW'(1);
                    if (timeout_hit) begin
                        timeout_err_d = 1'b1;
                        arb_active_d  = 1'b0;
                    end
                end
            end
            ST_WAIT_DONE: begin
                if (!tx_busy) begin
                    arb_active_d = 1'b0;
                end
            end
            default: begin
                arb_active_d = 1'b0;
            end
        endcase
    end

    // Output, pointer and counter registers
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            req_ready     <= '0;
            tx_data_valid <= 1'b0;
            tx_p_data     <= '0;
            tx_par_en     <= 1'b0;
            grant_id      <= '0;
            arb_active    <= 1'b0;
            timeout_err   <= 1'b0;
            rr_ptr_q      <= '0;
            cnt_q         <= '0;
        end else begin
            req_ready     <= req_ready_d;
            tx_data_valid <= tx_data_valid_d;
            tx_p_data     <= tx_p_data_d;
            tx_par_en     <= tx_par_en_d;
            grant_id      <= grant_id_d;
            arb_active    <= arb_active_d;
            timeout_err   <= timeout_err_d;
            rr_ptr_q      <= rr_ptr_d;
            cnt_q         <= cnt_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: grant vector table plus config-freeze, timeout,
// arb_en hold and mid-frame reset sequences.
module tb_uart_tx_arbiter;

    localparam int unsigned NUM_REQ      = 4;
    localparam int unsigned DATA_WIDTH   = 8;
    localparam int unsigned BUSY_TIMEOUT = 15;

    logic        CLK;
    logic        RST;
    logic        arb_en;
    logic        tx_busy;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  cfg_par_en;
    logic [3:0]  req_ready;
    logic        tx_data_valid;
    logic [7:0]  tx_p_data;
    logic        tx_par_en;
    logic [1:0]  grant_id;
    logic        arb_active;
    logic        timeout_err;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [3:0]  valid;
        logic [31:0] data;
        logic [3:0]  par;
        int unsigned g;
        logic [7:0]  byte_exp;
        logic        par_exp;
    } vec_t;

    vec_t vecs [10];

    uart_tx_arbiter #(
        .NUM_REQ      (NUM_REQ),
        .DATA_WIDTH   (DATA_WIDTH),
        .BUSY_TIMEOUT (BUSY_TIMEOUT)
    ) dut (
        .CLK           (CLK),
        .RST           (RST),
        .arb_en        (arb_en),
        .req_valid     (req_valid),
        .req_data      (req_data),
        .cfg_par_en    (cfg_par_en),
        .req_ready     (req_ready),
        .tx_busy       (tx_busy),
        .tx_data_valid (tx_data_valid),
        .tx_p_data     (tx_p_data),
        .tx_par_en     (tx_par_en),
        .grant_id      (grant_id),
        .arb_active    (arb_active),
        .timeout_err   (timeout_err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Returns at the negedge where tx_data_valid is first seen high
    task automatic wait_valid(input int maxc, output logic seen);
        seen = 1'b0;
        for (int c = 0; c < maxc && !seen; c++) begin
            @(negedge CLK);
            if (tx_data_valid) seen = 1'b1;
        end
    endtask

    // Transmitter model: busy rises one cycle after the start pulse, lasts blen cycles
    task automatic finish_frame(input int blen);
        @(negedge CLK);
        tx_busy = 1'b1;
        repeat (blen) @(negedge CLK);
        tx_busy = 1'b0;
        @(negedge CLK);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_req_ready"},   32'(req_ready),     32'h0);
        check({tag, "_tx_valid"},    32'(tx_data_valid), 32'h0);
        check({tag, "_tx_p_data"},   32'(tx_p_data),     32'h0);
        check({tag, "_tx_par_en"},   32'(tx_par_en),     32'h0);
        check({tag, "_grant_id"},    32'(grant_id),      32'h0);
        check({tag, "_arb_active"},  32'(arb_active),    32'h0);
        check({tag, "_timeout_err"}, 32'(timeout_err),   32'h0);
    endtask

    initial begin
        logic       seen;
        logic [3:0] oh;
        logic       act_at_to;
        int         first;
        int         pulses;

        vecs[0] = '{4'b0100, 32'h00A50000, 4'b0100, 2, 8'hA5, 1'b1};
        vecs[1] = '{4'b1111, 32'h44332211, 4'b0000, 3, 8'h44, 1'b0};
        vecs[2] = '{4'b1111, 32'h44332211, 4'b1010, 0, 8'h11, 1'b0};
        vecs[3] = '{4'b1111, 32'h44332211, 4'b1010, 1, 8'h22, 1'b1};
        vecs[4] = '{4'b1111, 32'h44332211, 4'b1010, 2, 8'h33, 1'b0};
        vecs[5] = '{4'b1111, 32'h44332211, 4'b1010, 3, 8'h44, 1'b1};
        vecs[6] = '{4'b0001, 32'h0000005A, 4'b0001, 0, 8'h5A, 1'b1};
        vecs[7] = '{4'b0001, 32'h000000C3, 4'b0000, 0, 8'hC3, 1'b0};
        vecs[8] = '{4'b1001, 32'h7E000001, 4'b1000, 3, 8'h7E, 1'b1};
        vecs[9] = '{4'b0110, 32'h00889900, 4'b0100, 1, 8'h99, 1'b0};

        RST        = 1'b0;
        arb_en     = 1'b0;
        tx_busy    = 1'b0;
        req_valid  = '0;
        req_data   = '0;
        cfg_par_en = '0;
        repeat (3) @(negedge CLK);
        check_all_zero("reset");
        RST    = 1'b1;
        arb_en = 1'b1;
        @(negedge CLK);

        // Grant table: round-robin pointer carries over from vector to vector
        foreach (vecs[v]) begin
            req_valid  = vecs[v].valid;
            req_data   = vecs[v].data;
            cfg_par_en = vecs[v].par;
            wait_valid(4, seen);
            check($sformatf("v%0d_valid", v), 32'(seen), 32'h1);
            if (seen) begin
                oh = 4'b0001 << vecs[v].g;
                check($sformatf("v%0d_req_ready", v),  32'(req_ready),  32'(oh));
                check($sformatf("v%0d_grant_id", v),   32'(grant_id),   vecs[v].g);
                check($sformatf("v%0d_tx_p_data", v),  32'(tx_p_data),  32'(vecs[v].byte_exp));
                check($sformatf("v%0d_tx_par_en", v),  32'(tx_par_en),  32'(vecs[v].par_exp));
                check($sformatf("v%0d_arb_active", v), 32'(arb_active), 32'h1);
                req_valid = '0;
                finish_frame(2);
                check($sformatf("v%0d_active_fall", v), 32'(arb_active),    32'h0);
                check($sformatf("v%0d_no_repulse", v),  32'(tx_data_valid), 32'h0);
            end
        end

        // Config and data changes while the frame is in flight are ignored
        req_valid  = 4'b0010;
        req_data   = 32'h00003C00;
        cfg_par_en = 4'b0010;
        wait_valid(4, seen);
        check("cfg_valid", 32'(seen), 32'h1);
        req_valid = '0;
        @(negedge CLK);
        tx_busy = 1'b1;
        @(negedge CLK);
        req_data   = 32'h0000FF00;
        cfg_par_en = 4'b0000;
        repeat (2) @(negedge CLK);
        check("cfg_mid_data", 32'(tx_p_data), 32'h3C);
        check("cfg_mid_par",  32'(tx_par_en), 32'h1);
        tx_busy = 1'b0;
        @(negedge CLK);
        check("cfg_end_active", 32'(arb_active), 32'h0);
        check("cfg_end_data",   32'(tx_p_data),  32'h3C);
        check("cfg_end_par",    32'(tx_par_en),  32'h1);
        req_valid = 4'b0010;
        wait_valid(4, seen);
        check("cfg_next_valid", 32'(seen),      32'h1);
        check("cfg_next_data",  32'(tx_p_data), 32'hFF);
        check("cfg_next_par",   32'(tx_par_en), 32'h0);
        req_valid = '0;
        finish_frame(1);

        // Busy never rises: timeout pulse exactly BUSY_TIMEOUT cycles into WAIT_BUSY
        req_valid  = 4'b1000;
        req_data   = 32'h55000000;
        cfg_par_en = 4'b0000;
        wait_valid(4, seen);
        check("to_valid", 32'(seen), 32'h1);
        req_valid = '0;
        first     = -1;
        act_at_to = 1'b1;
        for (int c = 1; c <= int'(BUSY_TIMEOUT) + 3 && first < 0; c++) begin
            @(negedge CLK);
            if (timeout_err) begin
                first     = c;
                act_at_to = arb_active;
            end
        end
        check("to_cycle",      32'(first),     32'(BUSY_TIMEOUT));
        check("to_arb_active", 32'(act_at_to), 32'h0);
        @(negedge CLK);
        check("to_pulse_len",  32'(timeout_err), 32'h0);
        req_valid  = 4'b0001;
        req_data   = 32'h00000066;
        cfg_par_en = 4'b0001;
        wait_valid(4, seen);
        check("to_next_valid", 32'(seen),      32'h1);
        check("to_next_grant", 32'(grant_id),  32'h0);
        check("to_next_data",  32'(tx_p_data), 32'h66);
        req_valid = '0;
        finish_frame(2);
        check("to_next_done",  32'(arb_active),  32'h0);
        check("to_next_noerr", 32'(timeout_err), 32'h0);

        // arb_en low mid-frame: frame completes, no new grant until re-enabled
        req_valid  = 4'b0001;
        req_data   = 32'h00340012;
        cfg_par_en = 4'b0000;
        wait_valid(4, seen);
        check("hold_valid", 32'(seen), 32'h1);
        req_valid = 4'b0100;
        arb_en    = 1'b0;
        finish_frame(3);
        check("hold_done", 32'(arb_active), 32'h0);
        pulses = 0;
        repeat (6) begin
            @(negedge CLK);
            if (tx_data_valid) pulses++;
        end
        check("hold_no_valid", 32'(pulses), 32'h0);
        arb_en = 1'b1;
        wait_valid(2, seen);
        check("reen_valid", 32'(seen),      32'h1);
        check("reen_grant", 32'(grant_id),  32'h2);
        check("reen_data",  32'(tx_p_data), 32'h34);
        req_valid = '0;
        finish_frame(1);

        // Reset in WAIT_DONE, then fairness from requester 0 with all requesters pending
        req_valid  = 4'b1111;
        req_data   = 32'h44332211;
        cfg_par_en = 4'b0101;
        wait_valid(4, seen);
        check("rst_pre_valid", 32'(seen), 32'h1);
        @(negedge CLK);
        tx_busy = 1'b1;
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        #1;
        check_all_zero("rst_mid");
        tx_busy = 1'b0;
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        check("rst_rel_valid", 32'(tx_data_valid), 32'h0);
        check("rst_rel_ready", 32'(req_ready),     32'h0);
        for (int i = 0; i < 6; i++) begin
            wait_valid(4, seen);
            check($sformatf("rr%0d_valid", i), 32'(seen), 32'h1);
            oh = 4'b0001 << (i % 4);
            check($sformatf("rr%0d_grant", i), 32'(grant_id),  32'(i % 4));
            check($sformatf("rr%0d_ready", i), 32'(req_ready), 32'(oh));
            check($sformatf("rr%0d_data", i),  32'(tx_p_data), 32'(((i % 4) + 1) * 17));
            check($sformatf("rr%0d_par", i),   32'(tx_par_en), 32'((i % 2) == 0));
            finish_frame(1);
        end
        req_valid = '0;
        repeat (2) @(negedge CLK);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin scheduler that shares one UART transmitter (TX FSM + serializer + parity + output mux) between NUM_REQ byte producers. It picks one pending requester, configures the transmitter's parity enable for that frame, issues a single-cycle data-valid pulse with the latched byte, and waits for the transmitter's busy flag to rise and fall before it grants again. It sits between the register/command layer and the UART TX top level.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- DATA_WIDTH, 8, byte width forwarded to the transmitter
- BUSY_TIMEOUT, 15, max cycles to wait for tx_busy to rise after issue (≥2)
- CLK  in  1  single clock, all logic on rising edge
- RST  in  1  asynchronous, active-low reset
- arb_en  in  1  1 = new grants allowed; 0 = finish in-flight frame, then hold
- req_valid  in  NUM_REQ  per-requester pending byte; held until its req_ready pulse
- req_data  in  NUM_REQ*DATA_WIDTH  packed bytes, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
- cfg_par_en  in  NUM_REQ  per-requester parity enable
- req_ready  out  NUM_REQ  one-hot, 1-cycle acknowledge to the granted requester
- tx_busy  in  1  busy from the UART transmitter
- tx_data_valid  out  1  1-cycle start pulse to the transmitter
- tx_p_data  out  DATA_WIDTH  byte to transmit, held stable from issue until frame end
- tx_par_en  out  1  parity enable to the transmitter, held stable for whole frame
- grant_id  out  $clog2(NUM_REQ)  index of current/last granted requester
- arb_active  out  1  1 from issue cycle until tx_busy falls (or timeout)
- timeout_err  out  1  1-cycle pulse when tx_busy fails to rise within BUSY_TIMEOUT

## Operation
- All outputs registered. Reset values: req_ready=0, tx_data_valid=0, tx_p_data=0, tx_par_en=0, grant_id=0, arb_active=0, timeout_err=0; rr_ptr=0, timeout counter=0, state ARB.
- States: ARB, ISSUE, WAIT_BUSY, WAIT_DONE.
- ARB: if arb_en=1, tx_busy=0 and |req_valid: winner g = first set bit of req_valid searching rr_ptr, rr_ptr+1, ... wrapping modulo NUM_REQ. Latch tx_p_data=req_data[g], tx_par_en=cfg_par_en[g], grant_id=g, rr_ptr=(g+1) mod NUM_REQ (wrap from NUM_REQ-1 to 0). Go ISSUE. Otherwise stay.
- ISSUE (exactly one cycle): tx_data_valid=1, req_ready[g]=1, arb_active=1. Clear timeout counter. Go WAIT_BUSY.
- WAIT_BUSY: tx_busy=1 -> WAIT_DONE. Else increment counter; when counter reaches BUSY_TIMEOUT -> timeout_err=1 for one cycle, arb_active=0, go ARB (byte is dropped, not retried).
- WAIT_DONE: stay while tx_busy=1; tx_busy=0 -> arb_active=0, go ARB.
- tx_p_data/tx_par_en change only in ARB on a grant; cfg_par_en changes mid-frame have no effect.
- req_valid/req_data sampled only in ARB; changes afterwards ignored for the current frame.
- arb_en deassertion never aborts an issued frame.
- Counter width $clog2(BUSY_TIMEOUT+1); no wrap since it stops at BUSY_TIMEOUT.

## Timing
- Grant latency: req_valid high with arbiter in ARB and tx_busy=0 at edge k -> tx_data_valid and req_ready high during cycle k+1 to k+2.
- Transmitter raises busy one cycle after it samples data-valid, so nominal path is ISSUE -> WAIT_BUSY (1 cycle) -> WAIT_DONE.
- Back-to-back: after tx_busy falls at edge m, state ARB at m; next tx_data_valid no earlier than cycle m+1. Minimum 1 idle cycle of tx_busy between frames; arbiter never uses the transmitter's STOP->START chaining.
- Simultaneous requests: exactly one grant per frame; the others remain pending.
- Reset mid-frame: all outputs and rr_ptr return to reset values asynchronously; no pulse generated on release.

## Test plan
- Single request: req_valid=4'b0100, byte 0xA5, par 1 -> one tx_data_valid pulse, tx_p_data=0xA5, tx_par_en=1, req_ready=4'b0100, grant_id=2; arb_active falls with tx_busy.
- Fairness: all four requesters continuously valid -> grant order 0,1,2,3,0,1 with no repeats; rr_ptr wraps 3->0.
- Mid-frame config change: toggle cfg_par_en[g] and req_data during WAIT_DONE -> tx_par_en/tx_p_data unchanged until next grant.
- Timeout: hold tx_busy=0 after issue -> timeout_err pulses exactly BUSY_TIMEOUT cycles into WAIT_BUSY; next grant proceeds normally.
- arb_en=0 during a frame -> frame completes, no new tx_data_valid while arb_en=0; re-enable -> grant within 2 cycles.
- Assert RST in WAIT_DONE -> all outputs 0, grant_id=0; after release, requester 0 wins first if pending.
